pipeline_ctrl: RTL

Stall/flush controller for the five-stage pipeline. It drives the PC-register enable, the IF/ID and ID/EX enable and flush controls, and the instruction-memory request. It resolves branch redirects, load-use hazards, multi-cycle instruction-memory waits and halt. The block sits beside the fetch and decode stages and also keeps saturating performance counters.

---
 rtl/pipeline_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl
//  Purpose  : Stall/flush controller for the five-stage pipeline, with
//             memory-wait timeout and saturating performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsrce,
    input  logic        memreade,
    input  logic [4:0]  rde,
    input  logic [4:0]  rs1d,
    input  logic [4:0]  rs2d,
    input  logic        haltd,
    input  logic        imem_ready,
    output logic        stallf,
    output logic        stalld,
    output logic        flushd,
    output logic        flushe,
    output logic        imem_req,
    output logic        halted,
    output logic        timeout_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        HALT    = 2'b10
    } state_t;

    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT - 1);
    localparam logic [15:0] c_cnt_max      = 16'hFFFF;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wait_cnt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_redirect_cnt;
    logic        r_timeout_err;

    logic        w_lu;
    logic        w_wait_clr;
    logic        w_wait_inc;
    logic        w_redirect;
    logic        w_set_terr;

    assign w_lu = memreade && (rde != 5'd0) && ((rde == rs1d) || (rde == rs2d));

    always_comb begin
        stallf     = 1'b0;
        stalld     = 1'b0;
        flushd     = 1'b0;
        flushe     = 1'b0;
        imem_req   = 1'b0;
        halted     = 1'b0;
        w_next     = r_state;
        w_wait_clr = 1'b0;
        w_wait_inc = 1'b0;
        w_redirect = 1'b0;
        w_set_terr = 1'b0;

        case (r_state)
            RUN: begin
                imem_req = 1'b1;
                if (pcsrce) begin
                    // A redirect squashes the wrong-path halt/load-use in Decode.
                    flushd     = 1'b1;
                    flushe     = 1'b1;
                    w_redirect = 1'b1;
                end else if (w_lu) begin
                    stallf = 1'b1;
                    stalld = 1'b1;
                    flushe = 1'b1;
                end else if (haltd) begin
                    stallf = 1'b1;
                    flushd = 1'b1;
                    w_next = HALT;
                end else if (!imem_ready) begin
                    stallf     = 1'b1;
                    flushd     = 1'b1;
                    w_next     = MEMWAIT;
                    w_wait_clr = 1'b1;
                end
            end
            MEMWAIT: begin
                imem_req = 1'b1;
                if (pcsrce) begin
                    flushd     = 1'b1;
                    flushe     = 1'b1;
                    w_redirect = 1'b1;
                    w_wait_clr = 1'b1;
                end else if (imem_ready) begin
                    w_next = RUN;
                end else begin
                    stallf = 1'b1;
                    flushd = 1'b1;
                    if (r_wait_cnt == c_timeout_last) begin
                        w_next     = HALT;
                        w_set_terr = 1'b1;
                    end else begin
                        w_wait_inc = 1'b1;
                    end
                end
            end
            HALT: begin
                stallf = 1'b1;
                flushd = 1'b1;
                halted = 1'b1;
            end
            default: begin
                w_next = RUN;
            end
        endcase

        if (rst) begin
            stallf   = 1'b0;
            stalld   = 1'b0;
            flushd   = 1'b0;
            flushe   = 1'b0;
            imem_req = 1'b0;
            halted   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= RUN;
            r_wait_cnt     <= 16'd0;
            r_stall_cnt    <= 16'd0;
            r_redirect_cnt <= 16'd0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_wait_clr) begin
                r_wait_cnt <= 16'd0;
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (stallf && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_redirect && (r_redirect_cnt != c_cnt_max)) begin
                r_redirect_cnt <= r_redirect_cnt + 16'd1;
            end
            if (w_set_terr) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err  = r_timeout_err;
    assign stall_cnt    = r_stall_cnt;
    assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire
